led_frame_buffer: RTL and testbench

Holds the cell array that feeds the LED refresh controller and owns its `cells`, `refresh` and `refresh_lock` inputs. Upstream logic (machine-state decoders, register file mirrors) writes individual cells over a simple addressed write port. Multi-cell updates can be grouped into transactions; while a transaction is open the block holds the refresh lock, so a frame never mixes old and new data. Refresh requests are rate-limited and only issued when content has changed or a forced refresh is requested.

---
 rtl/led_frame_buffer.sv | 136 +++++++++++++
 tb/tb_led_frame_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: the cell array feeding the LED refresh controller.
// Cells are written through an addressed port. Transactions hold the refresh
// lock so that a frame never shows a mix of old and new data. Refresh requests
// are rate-limited and are only raised when content changed or a refresh is forced.

package led_controller_defs;
  typedef enum logic {CELL_TYPE_LED = 1'b0, CELL_TYPE_DISPLAY = 1'b1} cell_type_t;
  typedef struct packed {
    cell_type_t  ctype;
    logic [1:0]  digits;
    logic [15:0] value;
  } cell_t;
endpackage

module led_frame_buffer
  import led_controller_defs::*;
#(
  parameter int ARRAY_LENGTH   = 400,
  parameter int ADDR_WIDTH     = 9,
  parameter int REFRESH_PERIOD = 1000000,
  parameter int LOCK_TIMEOUT   = 65536
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  cell_t                          wr_data,
  input  logic                           txn_begin,
  input  logic                           txn_end,
  input  logic                           force_refresh,
  output cell_t [ARRAY_LENGTH-1:0]       cells,
  output logic                           refresh,
  output logic                           refresh_lock,
  output logic                           dirty,
  output logic                           wr_err,
  output logic                           txn_timeout
);

  localparam int TW = $clog2(REFRESH_PERIOD);
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0]       T_LOAD  = TW'(REFRESH_PERIOD - 1);
  localparam logic [CW-1:0]       CNT_MAX = CW'(LOCK_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] LEN_A   = (ADDR_WIDTH + 1)'(ARRAY_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_TXN, S_SETTLE} state_t;

  state_t                    r_state, w_state_nxt;
  cell_t [ARRAY_LENGTH-1:0]  r_cells;
  logic [TW-1:0]             r_timer;
  logic [CW-1:0]             r_lock_cnt;
  logic                      r_lock, r_dirty, r_force, r_wr_err, r_txn_timeout;
  logic                      w_addr_ok, w_wr_ok, w_change, w_refresh, w_timeout;

  assign w_addr_ok = ({1'b0, wr_addr} < LEN_A);
  assign w_wr_ok   = wr_en & w_addr_ok;
  // The array index is only meaningful when the address is in range, so the compare is gated.
  assign w_change  = w_wr_ok && (wr_data != r_cells[wr_addr]);
  // Refresh is decoded from registered state only, so the clearing edge is the same edge that ends the pulse.
  assign w_refresh = (r_state == S_IDLE) && (r_timer == '0) && (r_dirty || r_force);

  assign cells        = r_cells;
  assign refresh      = w_refresh;
  assign refresh_lock = r_lock;
  assign dirty        = r_dirty;
  assign wr_err       = r_wr_err;
  assign txn_timeout  = r_txn_timeout;

  // Transaction FSM next state. The timeout fires only when no explicit close arrives in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:   if (txn_begin && !txn_end) w_state_nxt = S_TXN;
      S_TXN: begin
        if (txn_end) begin
          w_state_nxt = S_SETTLE;
        end else if (r_lock_cnt == CNT_MAX) begin
          w_state_nxt = S_SETTLE;
          w_timeout   = 1'b1;
        end
      end
      S_SETTLE: w_state_nxt = (txn_begin && !txn_end) ? S_TXN : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State, lock and lock-cycle counter. The counter restarts each time S_TXN is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_lock        <= 1'b0;
      r_lock_cnt    <= '0;
      r_txn_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lock        <= (w_state_nxt != S_IDLE);
      r_txn_timeout <= w_timeout;
      if (w_state_nxt == S_TXN && r_state != S_TXN) r_lock_cnt <= '0;
      else if (r_state == S_TXN)                     r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end

  // Cell storage. Writes are accepted in every state; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cells <= '0;
    end else if (w_wr_ok) begin
      r_cells[wr_addr] <= wr_data;
    end
  end

  // Dirty/force bookkeeping. A new set in the issuing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dirty  <= 1'b0;
      r_force  <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_dirty  <= w_change | (r_dirty & ~w_refresh);
      r_force  <= force_refresh | (r_force & ~w_refresh);
      r_wr_err <= wr_en & ~w_addr_ok;
    end
  end

  // Rate limiter. The timer reloads on each refresh and saturates at zero, which means expired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_refresh) begin
      r_timer <= T_LOAD;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer: writes, dirty tracking, rate limit,
// transactions, lock timeout, out-of-range writes and asynchronous reset.
module tb_led_frame_buffer;
  import led_controller_defs::*;

  localparam int AL = 400;
  localparam int AW = 9;
  localparam int RP = 1000;
  localparam int LT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  cell_t           wr_data = '0;
  logic            txn_begin = 1'b0;
  logic            txn_end = 1'b0;
  logic            force_refresh = 1'b0;
  cell_t [AL-1:0]  cells;
  logic            refresh, refresh_lock, dirty, wr_err, txn_timeout;

  led_frame_buffer #(
    .ARRAY_LENGTH(AL), .ADDR_WIDTH(AW), .REFRESH_PERIOD(RP), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .txn_begin(txn_begin), .txn_end(txn_end), .force_refresh(force_refresh),
    .cells(cells), .refresh(refresh), .refresh_lock(refresh_lock), .dirty(dirty),
    .wr_err(wr_err), .txn_timeout(txn_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, ref_cnt = 0, last_ref = 0, prev_ref = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Refresh pulses counted mid-cycle, with the cycle number each one landed in.
  always @(negedge clk) begin
    if (refresh) begin
      ref_cnt  <= ref_cnt + 1;
      prev_ref <= last_ref;
      last_ref <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic cell_t mk(input cell_type_t t, input logic [1:0] d, input logic [15:0] v);
    cell_t c;
    c.ctype  = t;
    c.digits = d;
    c.value  = v;
    return c;
  endfunction

  task automatic wr(input int a, input cell_t d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_ref(input string tag, input int maxc);
    int s, n;
    s = ref_cnt;
    n = 0;
    while (ref_cnt == s && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(ref_cnt != s), 1);
  endtask

  initial begin
    cell_t d1;
    int c0, c1, c2, c3;
    d1 = mk(CELL_TYPE_DISPLAY, 2'd2, 16'h1234);

    // reset state
    tick(2);
    chk("rst_refresh", 32'(refresh), 0);
    chk("rst_lock", 32'(refresh_lock), 0);
    chk("rst_dirty", 32'(dirty), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_timeout", 32'(txn_timeout), 0);
    chk("rst_cells", 32'(cells == '0), 1);
    rst = 1'b1;
    tick();

    // single write, timer expired: refresh follows immediately
    wr(5, d1);
    chk("w1_cell5", 32'(cells[5]), 32'(d1));
    chk("w1_dirty", 32'(dirty), 1);
    chk("w1_refresh", 32'(refresh), 1);
    tick();
    chk("w1_dirty_clr", 32'(dirty), 0);
    chk("w1_refresh_end", 32'(refresh), 0);
    chk("w1_ref_cnt", 32'(ref_cnt), 1);

    // identical rewrite leaves dirty alone; forced refresh waits for the timer
    wr(5, d1);
    chk("same_dirty", 32'(dirty), 0);
    chk("same_refresh", 32'(refresh), 0);
    force_refresh = 1'b1;
    tick();
    force_refresh = 1'b0;
    chk("force_deferred", 32'(refresh), 0);
    c0 = ref_cnt;
    wait_ref("force_issued", RP + 100);
    chk("force_interval", 32'(last_ref - prev_ref), RP);
    tick(5);
    chk("force_once", 32'(ref_cnt), 32'(c0 + 1));

    // rate limit: two changing writes 100 cycles apart
    tick(RP);
    wr(7, mk(CELL_TYPE_LED, 2'd0, 16'h0001));
    chk("rate_first_now", 32'(refresh), 1);
    tick();
    c1 = ref_cnt;
    tick(99);
    wr(8, mk(CELL_TYPE_LED, 2'd0, 16'h0002));
    chk("rate_second_dirty", 32'(dirty), 1);
    chk("rate_second_held", 32'(refresh), 0);
    wait_ref("rate_second_issued", RP);
    chk("rate_interval", 32'(last_ref - prev_ref), RP);
    chk("rate_no_early", 32'(ref_cnt), 32'(c1 + 1));

    // begin+end together and a lone end do nothing in idle
    tick(RP);
    txn_begin = 1'b1; txn_end = 1'b1;
    tick();
    txn_begin = 1'b0; txn_end = 1'b0;
    chk("idle_both_nolock", 32'(refresh_lock), 0);
    txn_end = 1'b1;
    tick();
    txn_end = 1'b0;
    chk("idle_end_nolock", 32'(refresh_lock), 0);

    // transaction of 10 writes, begin on the first, end on the last
    c2 = ref_cnt;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = mk(CELL_TYPE_LED, 2'd0, 16'(16'hA0 + i));
      txn_begin = (i == 0); txn_end = (i == 9);
      tick();
      chk("txn_lock", 32'(refresh_lock), 1);
      chk("txn_no_refresh", 32'(refresh), 0);
    end
    wr_en = 1'b0; txn_begin = 1'b0; txn_end = 1'b0;
    tick();
    chk("txn_lock_fall", 32'(refresh_lock), 0);
    chk("txn_refresh", 32'(refresh), 1);
    chk("txn_cell0", 32'(cells[0]), 32'(mk(CELL_TYPE_LED, 2'd0, 16'hA0)));
    chk("txn_cell9", 32'(cells[9]), 32'(mk(CELL_TYPE_LED, 2'd0, 16'hA9)));
    tick(3);
    chk("txn_single_refresh", 32'(ref_cnt), 32'(c2 + 1));

    // out-of-range write
    wr(400, mk(CELL_TYPE_DISPLAY, 2'd3, 16'hFFFF));
    chk("oor_wr_err", 32'(wr_err), 1);
    chk("oor_dirty", 32'(dirty), 0);
    chk("oor_cell0", 32'(cells[0]), 32'(mk(CELL_TYPE_LED, 2'd0, 16'hA0)));
    chk("oor_cell144", 32'(cells[144]), 0);
    tick();
    chk("oor_wr_err_end", 32'(wr_err), 0);

    // lock timeout with a pending dirty write
    tick(RP);
    txn_begin = 1'b1; wr_en = 1'b1; wr_addr = AW'(20); wr_data = mk(CELL_TYPE_LED, 2'd0, 16'h0055);
    tick();
    txn_begin = 1'b0; wr_en = 1'b0;
    chk("to_lock_rise", 32'(refresh_lock), 1);
    chk("to_dirty", 32'(dirty), 1);
    chk("to_held", 32'(refresh), 0);
    tick(15);
    chk("to_not_yet", 32'(txn_timeout), 0);
    chk("to_lock_hold", 32'(refresh_lock), 1);
    tick();
    chk("to_pulse", 32'(txn_timeout), 1);
    chk("to_settle_lock", 32'(refresh_lock), 1);
    chk("to_settle_norefresh", 32'(refresh), 0);
    tick();
    chk("to_pulse_end", 32'(txn_timeout), 0);
    chk("to_lock_fall", 32'(refresh_lock), 0);
    chk("to_refresh", 32'(refresh), 1);

    // asynchronous reset in the middle of a transaction
    tick(2);
    txn_begin = 1'b1; wr_en = 1'b1; wr_addr = AW'(30); wr_data = mk(CELL_TYPE_LED, 2'd1, 16'h0077);
    tick();
    txn_begin = 1'b0; wr_en = 1'b0;
    chk("mid_lock", 32'(refresh_lock), 1);
    tick(3);
    rst = 1'b0;
    #1;
    chk("mid_rst_lock", 32'(refresh_lock), 0);
    chk("mid_rst_refresh", 32'(refresh), 0);
    chk("mid_rst_dirty", 32'(dirty), 0);
    chk("mid_rst_cells", 32'(cells == '0), 1);
    chk("mid_rst_timeout", 32'(txn_timeout), 0);
    chk("mid_rst_wr_err", 32'(wr_err), 0);
    tick(2);
    rst = 1'b1;
    c3 = ref_cnt;
    tick(5);
    chk("post_rst_no_refresh", 32'(ref_cnt), 32'(c3));
    chk("post_rst_lock", 32'(refresh_lock), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
